// File: rtl/psum_accumulator_spad_if.sv
// ---------------------------------------------------------------------------
// psum_accumulator_spad_if
// Bundles the accumulate, drain-control and drain-output ports of the
// partial-sum scratchpad.
//   slave  : the scratchpad side (accepts beats, produces drained entries)
//   master : the producer/consumer side
// Signals:
//   in_valid/in_ready/in_addr/in_data/in_clear : accumulate beat
//   drain_start/drain_max                      : drain request
//   out_valid/out_ready/out_data/out_addr      : drained entry stream
//   drain_done                                 : final drain handshake pulse
//   busy                                       : scratchpad not idle
// ---------------------------------------------------------------------------
interface psum_accumulator_spad_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_clear;
    logic                  drain_start;
    logic [ADDR_WIDTH-1:0] drain_max;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  drain_done;
    logic                  busy;

    modport slave (
        input  in_valid, in_addr, in_data, in_clear, drain_start, drain_max, out_ready,
        output in_ready, out_valid, out_data, out_addr, drain_done, busy
    );

    modport master (
        output in_valid, in_addr, in_data, in_clear, drain_start, drain_max, out_ready,
        input  in_ready, out_valid, out_data, out_addr, drain_done, busy
    );
endinterface

// File: rtl/psum_accumulator_spad.sv
// ---------------------------------------------------------------------------
// psum_accumulator_spad
// Partial-sum scratchpad. Accepted beats add into (or overwrite, with
// in_clear) the addressed entry via a two-stage read-modify-write pipeline
// with same-address forwarding. A drain streams entries 0..drain_max out
// over a valid/ready port and zeroes each entry as it is read.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : psum_accumulator_spad_if.slave (accumulate, drain, output stream)
// ---------------------------------------------------------------------------
module psum_accumulator_spad #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    psum_accumulator_spad_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Beat committing this cycle (accepted last cycle)
    logic                  s2_vld_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic                  s2_clr_q;
    // Forwarded operand captured when a beat followed one to the same address
    logic                  fwd_sel_q;
    logic [DATA_WIDTH-1:0] fwd_val_q;

    logic [ADDR_WIDTH-1:0] max_q;
    logic [ADDR_WIDTH-1:0] rd_cnt_q;
    logic                  rd_done_q;
    logic                  out_valid_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;

    logic                  accept;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] sum;
    logic                  out_fire;
    logic                  last_fire;
    logic                  drain_issue;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
        accept      = bus.in_valid & (state_q == IDLE);
        operand     = fwd_sel_q ? fwd_val_q : rd_q;
        sum         = s2_clr_q ? s2_data_q : operand + s2_data_q;
        out_fire    = out_valid_q & bus.out_ready;
        last_fire   = out_fire & (out_addr_q == max_q);
        // Read k only when the output register is free (or freeing) so
        // nothing is lost under backpressure.
        drain_issue = (state_q == DRAIN) & ~rd_done_q & (~out_valid_q | bus.out_ready);
        // Accumulate and drain never overlap: DRAIN is entered with an empty
        // pipeline and no beats are accepted outside IDLE.
        ren         = accept | drain_issue;
        raddr       = drain_issue ? rd_cnt_q : bus.in_addr;
        wen         = s2_vld_q | drain_issue;
        waddr       = s2_vld_q ? s2_addr_q : rd_cnt_q;
        wdata       = s2_vld_q ? sum : '0;
    end

    // Storage is not reset. rd_q only updates on a read, so it also serves
    // as the held output data while a drained entry is stalled.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rd_q <= mem[raddr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            s2_vld_q    <= 1'b0;
            s2_addr_q   <= '0;
            s2_data_q   <= '0;
            s2_clr_q    <= 1'b0;
            fwd_sel_q   <= 1'b0;
            fwd_val_q   <= '0;
            max_q       <= '0;
            rd_cnt_q    <= '0;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            s2_vld_q <= accept;
            if (accept) begin
                s2_addr_q <= bus.in_addr;
                s2_data_q <= bus.in_data;
                s2_clr_q  <= bus.in_clear;
                // Memory read this cycle misses the write in flight
                fwd_sel_q <= s2_vld_q & (s2_addr_q == bus.in_addr);
                fwd_val_q <= sum;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.drain_start) begin
                        max_q     <= bus.drain_max;
                        rd_cnt_q  <= '0;
                        rd_done_q <= 1'b0;
                        state_q   <= (accept | s2_vld_q) ? FLUSH : DRAIN;
                    end
                end
                FLUSH: begin
                    if (!s2_vld_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_issue) begin
                        // Saturate at max so a full-range drain cannot wrap
                        if (rd_cnt_q == max_q) rd_done_q <= 1'b1;
                        else                   rd_cnt_q  <= rd_cnt_q + 1'b1;
                    end
                    if (last_fire) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (drain_issue) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= rd_cnt_q;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_valid_q ? rd_q : '0;
    assign bus.out_addr   = out_addr_q;
    assign bus.drain_done = last_fire;
    assign bus.busy       = (state_q != IDLE) | s2_vld_q;
endmodule

// File: tb/tb_psum_accumulator_spad.sv
module tb_psum_accumulator_spad;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_accumulator_spad_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_if ();
    psum_accumulator_spad #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: the scratchpad as a plain array of 16-bit values
    logic [15:0] mdl [256];
    logic [15:0] last_data;

    typedef struct {
        int          addr;
        logic [15:0] v0;    // cleared value
        logic [15:0] v1;    // added value
        int          gap;   // idle cycles between the two beats
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus_if.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input int a, input logic [15:0] d, input logic c);
        chk("beat_in_ready", longint'(bus_if.in_ready), 1);
        bus_if.in_valid = 1'b1;
        bus_if.in_addr  = a[7:0];
        bus_if.in_data  = d;
        bus_if.in_clear = c;
        mdl[a] = c ? d : 16'(mdl[a] + d);
        @(negedge clk);
    endtask

    // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready
    task automatic drain(input int mx, input int mode, input bit chkdata,
                         input bit with_beat, input int ba, input logic [15:0] bd,
                         output int lat);
        int          got   = 0;
        int          cyc   = 0;
        int          dones = 0;
        int          bound = 4 * (mx + 1) + 20;
        bit          stalled = 1'b0;
        logic [15:0] pd = '0;
        logic [7:0]  pa = '0;
        lat = -1;
        bus_if.in_valid = 1'b0;
        while (!bus_if.in_ready && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_start_ready", longint'(bus_if.in_ready), 1);
        bus_if.drain_start = 1'b1;
        bus_if.drain_max   = mx[7:0];
        if (with_beat) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_addr  = ba[7:0];
            bus_if.in_data  = bd;
            bus_if.in_clear = 1'b1;
            mdl[ba] = bd;
        end
        cyc = 0;
        while (got <= mx && cyc < bound) begin
            @(negedge clk);
            cyc++;
            bus_if.drain_start = 1'b0;
            bus_if.in_valid    = 1'b0;
            case (mode)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = ((cyc - 1) % 3 == 0);
                default: bus_if.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (bus_if.out_valid && lat < 0) lat = cyc;
            if (stalled) begin
                chk("hold_valid", longint'(bus_if.out_valid), 1);
                chk("hold_data", longint'(bus_if.out_data), longint'(pd));
                chk("hold_addr", longint'(bus_if.out_addr), longint'(pa));
            end
            if (bus_if.drain_done) begin
                dones++;
                chk("done_on_last", (bus_if.out_valid && bus_if.out_ready &&
                                     bus_if.out_addr == mx[7:0]) ? 1 : 0, 1);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                chk("drain_addr", longint'(bus_if.out_addr), got);
                if (chkdata) chk("drain_data", longint'(bus_if.out_data), longint'(mdl[got]));
                last_data = bus_if.out_data;
                got++;
            end
            stalled = bus_if.out_valid && !bus_if.out_ready;
            pd = bus_if.out_data;
            pa = bus_if.out_addr;
        end
        chk("drain_count", got, mx + 1);
        chk("drain_done_once", dones, 1);
        for (int i = 0; i <= mx; i++) mdl[i] = '0;
        @(negedge clk);
        #1;
        chk("post_in_ready", longint'(bus_if.in_ready), 1);
        chk("post_out_valid", longint'(bus_if.out_valid), 0);
        chk("post_done", longint'(bus_if.drain_done), 0);
        chk("post_busy", longint'(bus_if.busy), 0);
    endtask

    initial begin
        int lat;
        int cyc;
        rst                = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.in_addr     = '0;
        bus_if.in_data     = '0;
        bus_if.in_clear    = 1'b0;
        bus_if.drain_start = 1'b0;
        bus_if.drain_max   = '0;
        bus_if.out_ready   = 1'b1;
        last_data          = '0;
        for (int i = 0; i < 256; i++) mdl[i] = '0;

        tbl[0] = '{3, 16'd5,      16'd7,      0, 16'd12};
        tbl[1] = '{0, 16'h7FFF,   16'd1,      0, 16'h8000};
        tbl[2] = '{1, 16'hFFFD,   16'hFFFC,   1, 16'hFFF9};
        tbl[3] = '{7, 16'd100,    16'hFF9C,   2, 16'd0};
        tbl[4] = '{9, 16'hFFFF,   16'd1,      3, 16'd0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  longint'(bus_if.in_ready), 1);
        chk("rst_out_valid", longint'(bus_if.out_valid), 0);
        chk("rst_out_data",  longint'(bus_if.out_data), 0);
        chk("rst_out_addr",  longint'(bus_if.out_addr), 0);
        chk("rst_done",      longint'(bus_if.drain_done), 0);
        chk("rst_busy",      longint'(bus_if.busy), 0);
        rst = 1'b1;
        @(negedge clk);

        // Contents are undefined after reset: drain everything unchecked
        drain(255, 0, 1'b0, 1'b0, 0, '0, lat);
        chk("init_latency", lat, 2);

        // Table: clear, add after a gap, drain up to that address
        for (int i = 0; i < 5; i++) begin
            beat(tbl[i].addr, tbl[i].v0, 1'b1);
            if (tbl[i].gap > 0) idle(tbl[i].gap);
            beat(tbl[i].addr, tbl[i].v1, 1'b0);
            idle(2);
            drain(tbl[i].addr, i % 3, 1'b1, 1'b0, 0, '0, lat);
            chk("tbl_value", longint'(last_data), longint'(tbl[i].exp));
            chk("tbl_latency", lat, 2);
        end

        // Clear then add: beats at t, t+1 (forwarded), t+3
        beat(3, 16'd5, 1'b1);
        beat(3, 16'd7, 1'b0);
        idle(1);
        beat(3, 16'hFFFE, 1'b0);
        idle(2);
        drain(3, 0, 1'b1, 1'b0, 0, '0, lat);
        chk("clr_add_addr3", longint'(last_data), 10);

        // Backpressure with ready 1,0,0 repeating
        for (int a = 0; a < 5; a++) beat(a, 16'(a * 3 + 1), 1'b1);
        idle(2);
        drain(4, 1, 1'b1, 1'b0, 0, '0, lat);

        // Drained entries read back as zero
        beat(2, 16'd9, 1'b0);
        idle(2);
        drain(2, 0, 1'b1, 1'b0, 0, '0, lat);
        chk("drain_cleared_addr2", longint'(last_data), 9);

        // Random accumulation against the array model
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(20, 40);
            for (int k = 0; k < n; k++) begin
                beat($urandom_range(0, 15), 16'($urandom), ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            idle(2);
            drain(15, 2, 1'b1, 1'b0, 0, '0, lat);
        end

        // Start with a simultaneous beat, full address range
        drain(255, 0, 1'b1, 1'b1, 255, 16'd1, lat);
        chk("full_last_value", longint'(last_data), 1);
        chk("flush_visited", (lat > 2 && lat <= 4) ? 1 : 0, 1);

        // Reset during drain output 2
        bus_if.out_ready   = 1'b1;
        bus_if.drain_start = 1'b1;
        bus_if.drain_max   = 8'd10;
        cyc = 0;
        @(negedge clk);
        bus_if.drain_start = 1'b0;
        while (!(bus_if.out_valid && bus_if.out_addr == 8'd2) && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reach_out2", (cyc < 30) ? 1 : 0, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", longint'(bus_if.out_valid), 0);
        chk("mid_rst_busy",      longint'(bus_if.busy), 0);
        chk("mid_rst_done",      longint'(bus_if.drain_done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rel_in_ready", longint'(bus_if.in_ready), 1);
        chk("mid_rel_busy",     longint'(bus_if.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
